// File: rtl/ppi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ppi_pkg
//  Description : Shared constants and types for the clocked parallel
//                peripheral interface (control-word layout, addresses,
//                port C status bit positions, group mode type).
//  Revision    : 1.0  initial release
// ============================================================================
package ppi_pkg;

   // Control-word bit positions
   localparam int CW_FLAG     = 7;   // 1 = mode set, 0 = bit set/reset
   localparam int CW_AMODE_HI = 6;   // group A mode, upper bit (1x reserved)
   localparam int CW_AMODE_LO = 5;   // group A mode, lower bit
   localparam int CW_DIR_PA   = 4;   // 1 = port A input
   localparam int CW_DIR_PCU  = 3;   // 1 = port C upper half input
   localparam int CW_BMODE    = 2;   // group B mode, only 0 is legal
   localparam int CW_DIR_PB   = 1;   // 1 = port B input
   localparam int CW_DIR_PCL  = 0;   // 1 = port C lower half input

   // Group A operating mode
   typedef enum logic {
      MODE0 = 1'b0,
      MODE1 = 1'b1
   } grp_mode_e;

   // Register select addresses
   localparam logic [1:0] A_PA = 2'd0;
   localparam logic [1:0] A_PB = 2'd1;
   localparam logic [1:0] A_PC = 2'd2;
   localparam logic [1:0] A_CW = 2'd3;

   // Control word after reset: all ports input, mode 0
   localparam logic [7:0] CW_RESET_DEFAULT = 8'h9B;

   // Port C bits replaced by handshake status on reads in mode 1
   localparam int PC_INTRA = 3;
   localparam int PC_INTE  = 4;
   localparam int PC_IBFA  = 5;

   // A mode-set word is accepted only with a non-reserved A mode and B mode 0
   function automatic logic mode_word_ok(input logic amode_hi, input logic bmode);
      return !amode_hi && !bmode;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ppi_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module      : ppi_edge_sync
//  Description : Two-flop synchroniser for an asynchronous level plus a
//                single-cycle edge pulse (falling or rising, selectable).
//  Revision    : 1.0  initial release
// ============================================================================
module ppi_edge_sync #(
   parameter logic FALL_EDGE = 1'b1,   // 1 = pulse on fall, 0 = pulse on rise
   parameter logic RESET_VAL = 1'b1    // idle level of the input
)(
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic sync_out,
   output logic edge_pulse
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   // Synchronise the input and keep one cycle of history for edge detection
   always_ff @(posedge clk) begin
      if (reset) begin
         r_meta <= RESET_VAL;
         r_sync <= RESET_VAL;
         r_prev <= RESET_VAL;
      end else begin
         r_meta <= async_in;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign sync_out   = r_sync;
   assign edge_pulse = FALL_EDGE ? (r_prev & ~r_sync) : (~r_prev & r_sync);

endmodule
`default_nettype wire

// File: rtl/ppi_sync.sv
`default_nettype none
// ============================================================================
//  Module      : ppi_sync
//  Description : Clocked parallel peripheral interface. Three DW-bit ports
//                (A, B, C split in halves), control-word / BSR programming,
//                mode 0 basic I/O and mode 1 strobed input on port A.
//  Revision    : 1.0  initial release
// ============================================================================
module ppi_sync
   import ppi_pkg::*;
#(
   parameter int         DW       = 8,
   parameter logic [7:0] CW_RESET = CW_RESET_DEFAULT
)(
   input  logic          clk,
   input  logic          reset,
   input  logic          cs,
   input  logic          rd,
   input  logic          wr,
   input  logic [1:0]    a,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout,
   output logic          doe,
   input  logic [DW-1:0] pa_i,
   output logic [DW-1:0] pa_o,
   output logic          pa_oe,
   input  logic [DW-1:0] pb_i,
   output logic [DW-1:0] pb_o,
   output logic          pb_oe,
   input  logic [DW-1:0] pc_i,
   output logic [DW-1:0] pc_o,
   output logic [1:0]    pc_oe,
   input  logic          stba_n,
   output logic          ibfa,
   output logic          intra
);

   localparam int HW = DW / 2;
   localparam int IW = $clog2(DW);

   logic          r_wr_q;
   logic          r_rd_q;
   logic [7:0]    r_cw;
   logic [DW-1:0] r_pa_o;
   logic [DW-1:0] r_pb_o;
   logic [DW-1:0] r_pc_o;
   logic [DW-1:0] r_pa_l;
   logic          r_inte;
   logic          r_ibfa;
   logic          r_intra;
   logic [DW-1:0] r_dout;
   logic          r_doe;

   logic          w_stb_sync;
   logic          w_stb_fall;
   logic          w_wr_commit;
   logic          w_rd_done;
   logic          w_rd_active;
   logic          w_rd_pa;
   grp_mode_e     w_mode;
   logic          w_mode1;
   logic [DW-1:0] w_pa_mask;
   logic [DW-1:0] w_pb_mask;
   logic [DW-1:0] w_pc_mask;
   logic [5:0]    w_bsr_idx;
   logic          w_is_cw;
   logic          w_mode_set;
   logic          w_bsr;
   logic          w_bsr_inte;
   logic [DW-1:0] w_pc_bsr;
   logic [DW-1:0] w_pc_rd;
   logic [DW-1:0] w_rd_src;

   ppi_edge_sync #(
      .FALL_EDGE (1'b1),
      .RESET_VAL (1'b1)
   ) u_stba_sync (
      .clk        (clk),
      .reset      (reset),
      .async_in   (stba_n),
      .sync_out   (w_stb_sync),
      .edge_pulse (w_stb_fall)
   );

   // Bus strobe decode: writes commit on WR falling, reads complete on RD rising
   assign w_wr_commit = !cs && !wr && r_wr_q;
   assign w_rd_done   = !cs && rd && !r_rd_q;
   assign w_rd_active = !cs && !rd && wr;
   assign w_rd_pa     = w_rd_done && (a == A_PA);

   assign w_mode  = grp_mode_e'(r_cw[CW_AMODE_LO]);
   assign w_mode1 = (w_mode == MODE1);

   // Masks select the bits currently configured as outputs
   assign w_pa_mask = {DW{!r_cw[CW_DIR_PA]}};
   assign w_pb_mask = {DW{!r_cw[CW_DIR_PB]}};
   assign w_pc_mask = {{(DW-HW){!r_cw[CW_DIR_PCU]}}, {HW{!r_cw[CW_DIR_PCL]}}};

   assign w_bsr_idx  = {din[6:4], din[3:1]};
   assign w_is_cw    = w_wr_commit && (a == A_CW);
   assign w_mode_set = w_is_cw && din[CW_FLAG] &&
                       mode_word_ok(din[CW_AMODE_HI], din[CW_BMODE]);
   assign w_bsr      = w_is_cw && !din[CW_FLAG] && ({1'b0, w_bsr_idx} < 7'(DW));
   assign w_bsr_inte = w_bsr && w_mode1 && (w_bsr_idx == 6'(PC_INTE));

   // Port C latch with the addressed BSR bit replaced
   always_comb begin
      w_pc_bsr = r_pc_o;
      w_pc_bsr[w_bsr_idx[IW-1:0]] = din[0];
   end

   // Read data source for the selected register
   always_comb begin
      w_pc_rd = (r_pc_o & w_pc_mask) | (pc_i & ~w_pc_mask);
      if (w_mode1) begin
         w_pc_rd[PC_INTRA] = r_intra;
         w_pc_rd[PC_INTE]  = r_inte;
         w_pc_rd[PC_IBFA]  = r_ibfa;
      end
      w_rd_src = '0;
      case (a)
         A_PA:    w_rd_src = w_mode1 ? r_pa_l : (r_cw[CW_DIR_PA] ? pa_i : r_pa_o);
         A_PB:    w_rd_src = r_cw[CW_DIR_PB] ? pb_i : r_pb_o;
         A_PC:    w_rd_src = w_pc_rd;
         default: w_rd_src[7:0] = r_cw;
      endcase
   end

   // Registered copies of the strobes for edge qualification
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_q <= 1'b0;
         r_rd_q <= 1'b0;
      end else begin
         r_wr_q <= wr;
         r_rd_q <= rd;
      end
   end

   // CPU read data: follows the source while a read is active, holds otherwise
   always_ff @(posedge clk) begin
      if (reset) begin
         r_dout <= '0;
         r_doe  <= 1'b0;
      end else begin
         r_doe <= w_rd_active;
         if (w_rd_active) begin
            r_dout <= w_rd_src;
         end
      end
   end

   // Control word, output latches and INTE programming
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cw   <= CW_RESET;
         r_pa_o <= '0;
         r_pb_o <= '0;
         r_pc_o <= '0;
         r_inte <= 1'b0;
      end else if (w_mode_set) begin
         r_cw   <= din[7:0];
         r_pa_o <= '0;
         r_pb_o <= '0;
         r_pc_o <= '0;
         r_inte <= 1'b0;
      end else if (w_bsr) begin
         if (w_bsr_inte) begin
            r_inte <= din[0];
         end else begin
            r_pc_o <= w_pc_bsr;
         end
      end else if (w_wr_commit) begin
         case (a)
            A_PA: begin
               if (!w_mode1) begin
                  r_pa_o <= (r_pa_o & ~w_pa_mask) | (din & w_pa_mask);
               end
            end
            A_PB:    r_pb_o <= (r_pb_o & ~w_pb_mask) | (din & w_pb_mask);
            A_PC:    r_pc_o <= (r_pc_o & ~w_pc_mask) | (din & w_pc_mask);
            default: ;
         endcase
      end
   end

   // Mode-1 strobed input: an accepted strobe beats a simultaneous read clear
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pa_l  <= '0;
         r_ibfa  <= 1'b0;
         r_intra <= 1'b0;
      end else if (w_mode_set) begin
         r_ibfa  <= 1'b0;
         r_intra <= 1'b0;
      end else if (w_mode1) begin
         if (w_stb_fall && !r_ibfa) begin
            r_pa_l <= pa_i;
            r_ibfa <= 1'b1;
         end else if (w_rd_pa) begin
            r_ibfa <= 1'b0;
         end
         r_intra <= w_rd_pa ? 1'b0 : (r_inte & r_ibfa & w_stb_sync);
      end
   end

   assign dout  = r_dout;
   assign doe   = r_doe;
   assign pa_o  = r_pa_o;
   assign pb_o  = r_pb_o;
   assign pc_o  = r_pc_o;
   assign pa_oe = !r_cw[CW_DIR_PA] && !w_mode1;
   assign pb_oe = !r_cw[CW_DIR_PB];
   assign pc_oe = {!r_cw[CW_DIR_PCU], !r_cw[CW_DIR_PCL]};
   assign ibfa  = r_ibfa;
   assign intra = r_intra;

endmodule
`default_nettype wire

// File: tb/tb_ppi_sync.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ppi_sync
//  Description : Self-checking bench for ppi_sync: directed scenarios plus
//                randomized mode-0 traffic against a behavioural model, with
//                read data checked by a scoreboard monitor.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ppi_sync;
   import ppi_pkg::*;

   localparam int DW = 8;
   localparam int HW = DW / 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          cs = 1'b1, rd = 1'b1, wr = 1'b1;
   logic [1:0]    a = 2'd0;
   logic [DW-1:0] din = '0;
   logic [DW-1:0] dout;
   logic          doe;
   logic [DW-1:0] pa_i = '0, pb_i = '0, pc_i = '0;
   logic [DW-1:0] pa_o, pb_o, pc_o;
   logic          pa_oe, pb_oe;
   logic [1:0]    pc_oe;
   logic          stba_n = 1'b1;
   logic          ibfa, intra;

   int total = 0;
   int bad   = 0;
   logic [DW-1:0] exp_q[$];

   // Reference model state
   logic [7:0]    m_cw;
   logic [DW-1:0] m_pa, m_pb, m_pc, m_pal;
   logic          m_inte, m_ibfa;

   ppi_sync #(.DW(DW), .CW_RESET(8'h9B)) dut (
      .clk(clk), .reset(reset), .cs(cs), .rd(rd), .wr(wr), .a(a),
      .din(din), .dout(dout), .doe(doe),
      .pa_i(pa_i), .pa_o(pa_o), .pa_oe(pa_oe),
      .pb_i(pb_i), .pb_o(pb_o), .pb_oe(pb_oe),
      .pc_i(pc_i), .pc_o(pc_o), .pc_oe(pc_oe),
      .stba_n(stba_n), .ibfa(ibfa), .intra(intra)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Scoreboard monitor: every cycle with DOE high consumes one expected read
   always @(negedge clk) begin
      if (doe) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rd_unexpected: got dout=%h expected no read", dout);
         end else begin
            chk("rd_data", dout, exp_q.pop_front());
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   function automatic logic m_mode1();
      return m_cw[6:5] == 2'b01;
   endfunction

   function automatic logic [DW-1:0] m_read(input logic [1:0] ad);
      logic [DW-1:0] v;
      v = '0;
      case (ad)
         2'd0: v = m_mode1() ? m_pal : (m_cw[4] ? pa_i : m_pa);
         2'd1: v = m_cw[1] ? pb_i : m_pb;
         2'd2: begin
            v[HW-1:0]  = m_cw[0] ? pc_i[HW-1:0]  : m_pc[HW-1:0];
            v[DW-1:HW] = m_cw[3] ? pc_i[DW-1:HW] : m_pc[DW-1:HW];
            if (m_mode1()) begin
               v[3] = m_inte & m_ibfa;
               v[4] = m_inte;
               v[5] = m_ibfa;
            end
         end
         default: v[7:0] = m_cw;
      endcase
      return v;
   endfunction

   task automatic m_reset();
      m_cw = 8'h9B; m_pa = '0; m_pb = '0; m_pc = '0; m_pal = '0;
      m_inte = 1'b0; m_ibfa = 1'b0;
   endtask

   task automatic m_write(input logic [1:0] ad, input logic [DW-1:0] d);
      int idx;
      case (ad)
         2'd0: if (!m_mode1() && !m_cw[4]) m_pa = d;
         2'd1: if (!m_cw[1]) m_pb = d;
         2'd2: begin
            if (!m_cw[0]) m_pc[HW-1:0]  = d[HW-1:0];
            if (!m_cw[3]) m_pc[DW-1:HW] = d[DW-1:HW];
         end
         default: begin
            if (d[7]) begin
               if (!d[6] && !d[2]) begin
                  m_cw = d[7:0]; m_pa = '0; m_pb = '0; m_pc = '0;
                  m_inte = 1'b0; m_ibfa = 1'b0;
               end
            end else begin
               idx = int'({d[6:4], d[3:1]});
               if (idx < DW) begin
                  if (m_mode1() && idx == 4) m_inte = d[0];
                  else m_pc[idx] = d[0];
               end
            end
         end
      endcase
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [1:0] ad, input logic [DW-1:0] d);
      cs = 1'b0; wr = 1'b0; a = ad; din = d;
      tick();
      wr = 1'b1; cs = 1'b1;
      tick();
      m_write(ad, d);
   endtask

   task automatic bus_read(input logic [1:0] ad);
      cs = 1'b0; rd = 1'b0; a = ad;
      exp_q.push_back(m_read(ad));
      tick();
      rd = 1'b1;
      tick();
      cs = 1'b1;
      chk("doe_after_read", doe, 1'b0);
      if (ad == 2'd0 && m_mode1()) m_ibfa = 1'b0;
   endtask

   task automatic strobe(input logic [DW-1:0] v);
      pa_i = v;
      stba_n = 1'b0;
      repeat (4) tick();
      stba_n = 1'b1;
      repeat (4) tick();
      if (m_mode1() && !m_ibfa) begin
         m_pal = v;
         m_ibfa = 1'b1;
      end
   endtask

   task automatic check_pins();
      chk("pa_o", pa_o, m_pa);
      chk("pb_o", pb_o, m_pb);
      chk("pc_o", pc_o, m_pc);
      chk("pa_oe", pa_oe, !m_cw[4] && !m_mode1());
      chk("pb_oe", pb_oe, !m_cw[1]);
      chk("pc_oe", pc_oe, {!m_cw[3], !m_cw[0]});
      chk("ibfa", ibfa, m_ibfa);
      chk("intra", intra, m_inte & m_ibfa);
   endtask

   initial begin
      logic [7:0] r;
      int op;
      m_reset();

      // 1: strobe held low through reset must not commit
      cs = 1'b0; wr = 1'b0; a = A_CW; din = 8'h80;
      tick(); tick();
      reset = 1'b0;
      chk("rst_dout", dout, 8'h00);
      chk("rst_doe", doe, 1'b0);
      check_pins();
      tick();
      wr = 1'b1; cs = 1'b1;
      tick();
      check_pins();
      bus_read(A_CW);

      // 2: all outputs
      bus_write(A_CW, 8'h80);
      bus_write(A_PA, 8'hA5);
      bus_write(A_PB, 8'h3C);
      bus_write(A_PC, 8'h5A);
      check_pins();
      bus_read(A_PA); bus_read(A_PB); bus_read(A_PC); bus_read(A_CW);

      // 3: BSR set bit 7, clear bit 0
      bus_write(A_CW, 8'h80);
      bus_write(A_PC, 8'h01);
      bus_write(A_CW, 8'h0F);
      check_pins();
      bus_write(A_CW, 8'h00);
      check_pins();

      // 4: all inputs, pad readback, write to input port ignored
      bus_write(A_CW, 8'h9B);
      pa_i = 8'hC3;
      bus_read(A_PA);
      bus_write(A_PA, 8'hFF);
      check_pins();

      // 5: mode 1 strobed input with overrun
      bus_write(A_CW, 8'hB0);
      bus_write(A_CW, 8'h09);
      check_pins();
      strobe(8'h77);
      check_pins();
      pc_i = 8'hFF;
      bus_read(A_PC);
      strobe(8'h11);
      check_pins();
      bus_read(A_PA);
      check_pins();
      strobe(8'h11);
      check_pins();
      bus_read(A_PA);
      check_pins();
      bus_write(A_CW, 8'hA0);
      check_pins();

      // 6: reserved mode ignored, reset during pending handshake
      bus_write(A_CW, 8'hC0);
      bus_read(A_CW);
      strobe(8'h5C);
      check_pins();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      m_reset();
      check_pins();
      bus_read(A_CW);

      // Randomized mode-0 traffic
      for (int i = 0; i < 200; i++) begin
         op = int'($urandom_range(0, 9));
         r = 8'($urandom);
         pa_i = 8'($urandom); pb_i = 8'($urandom); pc_i = 8'($urandom);
         case (op)
            0: bus_write(A_CW, {1'b1, 2'b00, r[4], r[3], 1'b0, r[1:0]});
            1: bus_write(A_CW, {1'b1, r[6:0]} | (r[7] ? 8'h40 : 8'h04));
            2: bus_write(A_CW, {1'b0, r[6:0]});
            3, 4, 5: bus_write(2'($urandom_range(0, 2)), r);
            default: bus_read(2'($urandom_range(0, 3)));
         endcase
         check_pins();
      end

      repeat (4) tick();
      chk("rd_queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
